ddr2_init_sequencer: RTL and testbench



---
 rtl/ddr2_pkg.sv | 71 +++++++
 rtl/ddr2_wait_timer.sv | 33 +++
 rtl/ddr2_init_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_ddr2_init_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_pkg.sv
// Shared definitions for the DDR2 power-up initialization sequencer:
// command encodings, sequencer states, mode register field positions
// and helpers that build the mode register address words.
package ddr2_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP      = 4'b0111;
  localparam logic [3:0] CMD_PRE      = 4'b0010;
  localparam logic [3:0] CMD_REF      = 4'b0001;
  localparam logic [3:0] CMD_MRS      = 4'b0000;
  localparam logic [3:0] CMD_DESELECT = 4'b1111;

  // Mode register / address field positions
  localparam int A10_PRE_ALL = 10;
  localparam int A8_DLL_RST  = 8;
  localparam int OCD_MSB     = 9;
  localparam int OCD_LSB     = 7;
  localparam int A0_DLL_DIS  = 0;

  localparam logic [2:0] OCD_FIELD_DEFAULT = 3'b111;
  localparam logic [2:0] OCD_FIELD_EXIT    = 3'b000;

  typedef enum logic [3:0] {
    ST_CKE_LOW      = 4'd0,
    ST_NOP_WAIT     = 4'd1,
    ST_PRE1         = 4'd2,
    ST_EMR2         = 4'd3,
    ST_EMR3         = 4'd4,
    ST_EMR_DLL      = 4'd5,
    ST_MR_DLLRST    = 4'd6,
    ST_PRE2         = 4'd7,
    ST_REF1         = 4'd8,
    ST_REF2         = 4'd9,
    ST_MR           = 4'd10,
    ST_EMR_OCD_DEF  = 4'd11,
    ST_EMR_OCD_EXIT = 4'd12,
    ST_DLL_WAIT     = 4'd13,
    ST_DONE         = 4'd14
  } init_state_t;

  // Larger of two integers, used to size the shared counters.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Address word for PRECHARGE ALL: only A10 set.
  function automatic logic [12:0] pre_all_addr();
    logic [12:0] a;
    a = 13'h0000;
    a[A10_PRE_ALL] = 1'b1;
    return a;
  endfunction

  // MR word: user value with the DLL reset bit forced.
  function automatic logic [12:0] mr_addr(input logic [12:0] base, input logic dll_rst);
    logic [12:0] a;
    a = base;
    a[A8_DLL_RST] = dll_rst;
    return a;
  endfunction

  // EMR word: user value with DLL enabled (A0=0) and the OCD field forced.
  function automatic logic [12:0] emr_addr(input logic [12:0] base, input logic [2:0] ocd);
    logic [12:0] a;
    a = base;
    a[A0_DLL_DIS] = 1'b0;
    a[OCD_MSB:OCD_LSB] = ocd;
    return a;
  endfunction

endpackage

// File: rtl/ddr2_wait_timer.sv
// Loadable saturating down-counter. done is high while the count is zero,
// i.e. during the last cycle of a wait that was loaded with (length - 1).
module ddr2_wait_timer
  import ddr2_pkg::*;
#(
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_r;

  // Count down toward zero, reload on request, hold at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= RESET_VAL;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {W{1'b0}});

endmodule

// File: rtl/ddr2_init_sequencer.sv
// DDR2 power-up initialization sequencer. Walks the JEDEC init command
// sequence with parameterized spacing, then raises init_done (sticky),
// which gates ELF preloading in the downstream memory model wrapper.
module ddr2_init_sequencer
  import ddr2_pkg::*;
#(
  parameter int          CKE_WAIT  = 40000,
  parameter int          T_NOP     = 80,
  parameter int          T_RP      = 4,
  parameter int          T_MRD     = 2,
  parameter int          T_RFC     = 26,
  parameter int          T_DLL     = 200,
  parameter logic [12:0] MR_VALUE  = 13'h0443,
  parameter logic [12:0] EMR_VALUE = 13'h0004
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [2:0]  ba,
  output logic [12:0] addr,
  output logic        odt,
  output logic        init_done
);

  localparam int MAX_WAIT = max_int(max_int(max_int(CKE_WAIT, T_NOP), max_int(T_RP, T_MRD)),
                                    max_int(T_RFC, T_DLL));
  localparam int CW = $clog2(MAX_WAIT) + 1;

  localparam logic [CW-1:0] CKE_LOW_LOAD = CW'(CKE_WAIT - 1);
  localparam logic [CW-1:0] DLL_LAST     = CW'(T_DLL - 1);
  localparam logic [CW-1:0] CNT_MAX      = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE      = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};

  init_state_t   state_r;
  init_state_t   succ_s;
  logic          advance_s;
  logic          timer_done_s;
  logic          dll_ready_s;
  logic          dll_run_r;
  logic [CW-1:0] dll_cnt_r;
  logic [CW-1:0] wait_len_s;
  logic [CW-1:0] timer_load_val_s;

  logic          nxt_cke_s;
  logic [3:0]    nxt_cmd_s;
  logic [2:0]    nxt_ba_s;
  logic [12:0]   nxt_addr_s;

  // The counter starts at CKE_WAIT-1 so the cke-low phase spans exactly
  // CKE_WAIT cycles measured from reset release.
  ddr2_wait_timer #(
    .W         (CW),
    .RESET_VAL (CKE_LOW_LOAD)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (advance_s),
    .load_val (timer_load_val_s),
    .done     (timer_done_s)
  );

  // DLL_WAIT may exit on the next edge: the counter is one short of T_DLL now.
  assign dll_ready_s = dll_run_r && (dll_cnt_r >= DLL_LAST);

  // Successor state and whether the current state is finished this cycle.
  always_comb begin
    succ_s    = state_r;
    advance_s = 1'b0;
    case (state_r)
      ST_CKE_LOW:      begin succ_s = ST_NOP_WAIT;     advance_s = timer_done_s; end
      ST_NOP_WAIT:     begin succ_s = ST_PRE1;         advance_s = timer_done_s; end
      ST_PRE1:         begin succ_s = ST_EMR2;         advance_s = timer_done_s; end
      ST_EMR2:         begin succ_s = ST_EMR3;         advance_s = timer_done_s; end
      ST_EMR3:         begin succ_s = ST_EMR_DLL;      advance_s = timer_done_s; end
      ST_EMR_DLL:      begin succ_s = ST_MR_DLLRST;    advance_s = timer_done_s; end
      ST_MR_DLLRST:    begin succ_s = ST_PRE2;         advance_s = timer_done_s; end
      ST_PRE2:         begin succ_s = ST_REF1;         advance_s = timer_done_s; end
      ST_REF1:         begin succ_s = ST_REF2;         advance_s = timer_done_s; end
      ST_REF2:         begin succ_s = ST_MR;           advance_s = timer_done_s; end
      ST_MR:           begin succ_s = ST_EMR_OCD_DEF;  advance_s = timer_done_s; end
      ST_EMR_OCD_DEF:  begin succ_s = ST_EMR_OCD_EXIT; advance_s = timer_done_s; end
      ST_EMR_OCD_EXIT: begin
        succ_s    = dll_ready_s ? ST_DONE : ST_DLL_WAIT;
        advance_s = timer_done_s;
      end
      ST_DLL_WAIT:     begin succ_s = ST_DONE;         advance_s = dll_ready_s; end
      ST_DONE:         begin succ_s = ST_DONE;         advance_s = 1'b0; end
      default:         begin succ_s = ST_CKE_LOW;      advance_s = 1'b1; end
    endcase
  end

  // Length of the wait that follows entry into the successor state.
  always_comb begin
    wait_len_s = CNT_ONE;
    case (succ_s)
      ST_NOP_WAIT:     wait_len_s = CW'(T_NOP);
      ST_PRE1,
      ST_PRE2:         wait_len_s = CW'(T_RP);
      ST_EMR2,
      ST_EMR3,
      ST_EMR_DLL,
      ST_MR_DLLRST,
      ST_MR,
      ST_EMR_OCD_DEF,
      ST_EMR_OCD_EXIT: wait_len_s = CW'(T_MRD);
      ST_REF1,
      ST_REF2:         wait_len_s = CW'(T_RFC);
      default:         wait_len_s = CNT_ONE;
    endcase
    timer_load_val_s = wait_len_s - CNT_ONE;
  end

  // Pin values for the next cycle: the entry command of a new state,
  // otherwise DESELECT while cke is low and NOP everywhere else.
  always_comb begin
    nxt_cke_s  = 1'b1;
    nxt_cmd_s  = CMD_NOP;
    nxt_ba_s   = 3'd0;
    nxt_addr_s = 13'h0000;
    if (advance_s) begin
      case (succ_s)
        ST_NOP_WAIT:     nxt_cmd_s = CMD_NOP;
        ST_PRE1,
        ST_PRE2:         begin nxt_cmd_s = CMD_PRE; nxt_addr_s = pre_all_addr(); end
        ST_EMR2:         begin nxt_cmd_s = CMD_MRS; nxt_ba_s = 3'd2; end
        ST_EMR3:         begin nxt_cmd_s = CMD_MRS; nxt_ba_s = 3'd3; end
        ST_EMR_DLL,
        ST_EMR_OCD_EXIT: begin
          nxt_cmd_s  = CMD_MRS;
          nxt_ba_s   = 3'd1;
          nxt_addr_s = emr_addr(EMR_VALUE, OCD_FIELD_EXIT);
        end
        ST_MR_DLLRST:    begin
          nxt_cmd_s  = CMD_MRS;
          nxt_addr_s = mr_addr(MR_VALUE, 1'b1);
        end
        ST_REF1,
        ST_REF2:         nxt_cmd_s = CMD_REF;
        ST_MR:           begin
          nxt_cmd_s  = CMD_MRS;
          nxt_addr_s = mr_addr(MR_VALUE, 1'b0);
        end
        ST_EMR_OCD_DEF:  begin
          nxt_cmd_s  = CMD_MRS;
          nxt_ba_s   = 3'd1;
          nxt_addr_s = emr_addr(EMR_VALUE, OCD_FIELD_DEFAULT);
        end
        ST_DLL_WAIT,
        ST_DONE:         nxt_cmd_s = CMD_NOP;
        default:         begin nxt_cke_s = 1'b0; nxt_cmd_s = CMD_DESELECT; end
      endcase
    end else if (state_r == ST_CKE_LOW) begin
      nxt_cke_s = 1'b0;
      nxt_cmd_s = CMD_DESELECT;
    end else begin
      nxt_cke_s = 1'b1;
      nxt_cmd_s = CMD_NOP;
    end
  end

  // Sequencer state and registered DDR2 pins; init_done is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_CKE_LOW;
      cke       <= 1'b0;
      cs_n      <= 1'b1;
      ras_n     <= 1'b1;
      cas_n     <= 1'b1;
      we_n      <= 1'b1;
      ba        <= 3'd0;
      addr      <= 13'h0000;
      odt       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      if (advance_s) begin
        state_r <= succ_s;
      end else begin
        state_r <= state_r;
      end
      cke                       <= nxt_cke_s;
      {cs_n, ras_n, cas_n, we_n} <= nxt_cmd_s;
      ba                        <= nxt_ba_s;
      addr                      <= nxt_addr_s;
      odt                       <= 1'b0;
      init_done                 <= init_done | (advance_s && (succ_s == ST_DONE));
    end
  end

  // DLL lock counter: cleared when the DLL-reset MR issues, then saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dll_run_r <= 1'b0;
      dll_cnt_r <= CNT_ZERO;
    end else if (advance_s && (succ_s == ST_MR_DLLRST)) begin
      dll_run_r <= 1'b1;
      dll_cnt_r <= CNT_ZERO;
    end else if (dll_run_r && (dll_cnt_r != CNT_MAX)) begin
      dll_run_r <= dll_run_r;
      dll_cnt_r <= dll_cnt_r + CNT_ONE;
    end else begin
      dll_run_r <= dll_run_r;
      dll_cnt_r <= dll_cnt_r;
    end
  end

endmodule

// File: tb/tb_ddr2_init_sequencer.sv
// Directed bench for ddr2_init_sequencer: two instances (T_DLL=20 and
// T_DLL=1) with short waits, checked against hand-computed cycle tables.
module tb_ddr2_init_sequencer;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;
  localparam logic [3:0] DES = 4'b1111;
  localparam int NCYC = 60;

  logic clk;
  logic rst_n;

  logic cke_a, cs_n_a, ras_n_a, cas_n_a, we_n_a, odt_a, done_a;
  logic [2:0] ba_a;
  logic [12:0] addr_a;
  logic cke_b, cs_n_b, ras_n_b, cas_n_b, we_n_b, odt_b, done_b;
  logic [2:0] ba_b;
  logic [12:0] addr_b;

  int n_checks = 0;
  int n_fail = 0;

  logic [3:0]  tr_cmd_a  [NCYC];
  logic        tr_cke_a  [NCYC];
  logic [2:0]  tr_ba_a   [NCYC];
  logic [12:0] tr_addr_a [NCYC];
  logic        tr_odt_a  [NCYC];
  logic        tr_done_a [NCYC];
  logic [3:0]  tr_cmd_b  [NCYC];
  logic        tr_done_b [NCYC];

  // Expected command stream (cycle numbers from reset release)
  int          exp_cyc  [11] = '{15, 18, 20, 22, 24, 26, 29, 33, 37, 39, 41};
  logic [3:0]  exp_cmd  [11] = '{PRE, MRS, MRS, MRS, MRS, PRE, REF, REF, MRS, MRS, MRS};
  logic [2:0]  exp_ba   [11] = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
  logic [12:0] exp_addr [11] = '{13'h0400, 13'h0000, 13'h0000, 13'h0004, 13'h0543, 13'h0400,
                                 13'h0000, 13'h0000, 13'h0443, 13'h0384, 13'h0004};

  ddr2_init_sequencer #(
    .CKE_WAIT(10), .T_NOP(5), .T_RP(3), .T_MRD(2), .T_RFC(4), .T_DLL(20)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .cke(cke_a), .cs_n(cs_n_a), .ras_n(ras_n_a),
    .cas_n(cas_n_a), .we_n(we_n_a), .ba(ba_a), .addr(addr_a), .odt(odt_a),
    .init_done(done_a)
  );

  ddr2_init_sequencer #(
    .CKE_WAIT(10), .T_NOP(5), .T_RP(3), .T_MRD(2), .T_RFC(4), .T_DLL(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .cke(cke_b), .cs_n(cs_n_b), .ras_n(ras_n_b),
    .cas_n(cas_n_b), .we_n(we_n_b), .ba(ba_b), .addr(addr_b), .odt(odt_b),
    .init_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int c);
    tr_cmd_a[c]  = {cs_n_a, ras_n_a, cas_n_a, we_n_a};
    tr_cke_a[c]  = cke_a;
    tr_ba_a[c]   = ba_a;
    tr_addr_a[c] = addr_a;
    tr_odt_a[c]  = odt_a;
    tr_done_a[c] = done_a;
    tr_cmd_b[c]  = {cs_n_b, ras_n_b, cas_n_b, we_n_b};
    tr_done_b[c] = done_b;
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_cke_a"},  {31'd0, cke_a}, 32'd0);
    check({tag, "_cmd_a"},  {28'd0, cs_n_a, ras_n_a, cas_n_a, we_n_a}, {28'd0, DES});
    check({tag, "_ba_a"},   {29'd0, ba_a}, 32'd0);
    check({tag, "_addr_a"}, {19'd0, addr_a}, 32'd0);
    check({tag, "_odt_a"},  {31'd0, odt_a}, 32'd0);
    check({tag, "_done_a"}, {31'd0, done_a}, 32'd0);
    check({tag, "_cke_b"},  {31'd0, cke_b}, 32'd0);
    check({tag, "_cmd_b"},  {28'd0, cs_n_b, ras_n_b, cas_n_b, we_n_b}, {28'd0, DES});
    check({tag, "_babaddr_b"}, {16'd0, ba_b, addr_b}, 32'd0);
    check({tag, "_odtdone_b"}, {30'd0, odt_b, done_b}, 32'd0);
  endtask

  task automatic check_cke_phase(input string tag);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("%s_cke_low_c%0d", tag, c), {31'd0, tr_cke_a[c]}, 32'd0);
      check($sformatf("%s_deselect_c%0d", tag, c), {28'd0, tr_cmd_a[c]}, {28'd0, DES});
    end
    for (int c = 10; c < 15; c++) begin
      check($sformatf("%s_cke_high_c%0d", tag, c), {31'd0, tr_cke_a[c]}, 32'd1);
      check($sformatf("%s_nop_c%0d", tag, c), {28'd0, tr_cmd_a[c]}, {28'd0, NOP});
    end
    check({tag, "_pre1_cmd"}, {28'd0, tr_cmd_a[15]}, {28'd0, PRE});
    check({tag, "_pre1_addr"}, {19'd0, tr_addr_a[15]}, 32'h0400);
  endtask

  initial begin
    int q_cyc [$];
    int idle_bad;
    int odt_bad;
    int first_a;
    int first_b;
    int cnt_b;
    int done_bad;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_pins("por");

    // Release reset away from the clock edge; cycle 0 starts here
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    sample(0);
    for (int c = 1; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      sample(c);
    end

    check_cke_phase("run1");

    // Command stream of the T_DLL=20 instance
    idle_bad = 0;
    odt_bad = 0;
    for (int c = 0; c < NCYC; c++) begin
      if (tr_odt_a[c] !== 1'b0) odt_bad++;
      if (tr_cmd_a[c] === NOP || tr_cmd_a[c] === DES) begin
        if (tr_ba_a[c] !== 3'd0 || tr_addr_a[c] !== 13'h0000) idle_bad++;
      end else begin
        q_cyc.push_back(c);
      end
    end
    check("odt_zero_cycles_bad", odt_bad, 32'd0);
    check("idle_ba_addr_bad", idle_bad, 32'd0);
    check("cmd_count_a", q_cyc.size(), 32'd11);
    for (int i = 0; i < 11; i++) begin
      if (i < q_cyc.size()) begin
        check($sformatf("cmd%0d_cycle", i), q_cyc[i], exp_cyc[i]);
        check($sformatf("cmd%0d_code", i), {28'd0, tr_cmd_a[exp_cyc[i]]}, {28'd0, exp_cmd[i]});
        check($sformatf("cmd%0d_ba", i), {29'd0, tr_ba_a[exp_cyc[i]]}, {29'd0, exp_ba[i]});
        check($sformatf("cmd%0d_addr", i), {19'd0, tr_addr_a[exp_cyc[i]]}, {19'd0, exp_addr[i]});
      end
    end

    // init_done: T_DLL after MR(DLL reset) for A, T_MRD after OCD exit for B
    first_a = -1;
    first_b = -1;
    cnt_b = 0;
    for (int c = NCYC - 1; c >= 0; c--) begin
      if (tr_done_a[c] === 1'b1) first_a = c;
      if (tr_done_b[c] === 1'b1) first_b = c;
    end
    for (int c = 0; c < NCYC; c++) begin
      if (tr_cmd_b[c] !== NOP && tr_cmd_b[c] !== DES) cnt_b++;
    end
    check("done_rise_a", first_a, 32'd44);
    check("done_rise_b", first_b, 32'd43);
    check("cmd_count_b", cnt_b, 32'd11);
    check("ocd_exit_b", {28'd0, tr_cmd_b[41]}, {28'd0, MRS});

    // Stay in DONE for 1000 cycles
    done_bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      if (cke_a !== 1'b1 || {cs_n_a, ras_n_a, cas_n_a, we_n_a} !== NOP || done_a !== 1'b1) done_bad++;
      if (cke_b !== 1'b1 || {cs_n_b, ras_n_b, cas_n_b, we_n_b} !== NOP || done_b !== 1'b1) done_bad++;
      if (ba_a !== 3'd0 || addr_a !== 13'h0000) done_bad++;
    end
    check("done_hold_bad", done_bad, 32'd0);

    // Restart, then hit reset during REF1
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    sample(0);
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      sample(c);
    end
    check("rerun_ref1_cmd", {28'd0, tr_cmd_a[29]}, {28'd0, REF});
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_pins("midrst");

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    sample(0);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      sample(c);
    end
    check_cke_phase("run2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
